johnson_phase_checker: RTL and testbench
========================================

// Module: johnson_phase_checker
// PURPOSE
//  Downstream consumer of the 5-stage twisted-ring (Johnson) counter. Registers counter state a..e each
//  enabled cycle and decodes it to a binary phase index and a one-hot phase vector.
//  Flags illegal codes and checks each sample is the legal successor of the previous one.
//  Runs a lock state machine and keeps a saturating error count for system health monitoring.
// PARAMETERS
//  N        5  ring length; legal code count = 2N
//  PW       4  phase index width, >= clog2(2N)
//  ERRW     8  error counter width
//  LOCK_CNT 3  consecutive successor transitions needed to lock (1..15)
// PORTS
//  clk        in   1     clock, all state updates on posedge
//  clear      in   1     reset, synchronous, active-high
//  en         in   1     sample strobe; code captured only when en=1
//  code       in   N     ring state, code[N-1]=a (first stage) .. code[0]=last stage
//  phase      out  PW    decoded phase index 0..2N-1 (0 when illegal)
//  onehot     out  2N    onehot[phase]=1; all zero when illegal
//  legal      out  1     last sampled code is a legal Johnson code
//  locked     out  1     FSM in LOCKED
//  err_pulse  out  1     one-cycle pulse per detected error
//  err_count  out  ERRW  saturating error total
// BEHAVIOUR
//  Clock and reset: one clock. Reset is synchronous and active-high.
//  Reset (clear=1 at posedge) sets: phase=0, onehot=0, legal=0, locked=0, err_pulse=0,
//   err_count=0, FSM=INIT, streak=0. clear has priority over en.
//  Decode: legal codes have k leading ones then zeros (phase k, k=0..N), or
//   m leading zeros then ones (phase N+m, m=1..N-1).
//   N=5 codes: 00000=0, 10000=1, 11000=2, 11100=3, 11110=4, 11111=5,
//   01111=6, 00111=7, 00011=8, 00001=9. Any other code is illegal.
//  Latency: code sampled at edge t with en=1 -> phase/onehot/legal valid after edge t
//   (registered, 1 cycle). en=0 holds every output except err_pulse, which clears to 0.
//  Transition check on each enabled sample (previous legal phase p, new phase q):
//   - q==(p+1) mod 2N: successor; streak+1, saturating at LOCK_CNT.
//   - q==p: hold; no error, streak unchanged.
//   - anything else, or new code illegal: error.
//   - Wrap 2N-1 -> 0 is a successor.
//   - A sample following an illegal sample is never checked; it only reloads p.
//  FSM:
//   - INIT: first enabled sample after clear goes to ACQ; no check, no error.
//     An illegal first sample still counts as an error.
//   - ACQ: on error, streak=0 and stay in ACQ. When streak reaches LOCK_CNT, go to LOCKED.
//   - LOCKED: locked=1. On error, go to ACQ with streak=0 and locked=0 on the same edge.
//  Errors in ACQ and LOCKED: err_pulse=1 for one cycle and err_count+1, saturating at 2^ERRW-1.
//  Reset mid-operation: all state is discarded. The next enabled sample is treated as first (INIT).
// CONFIGURATION
//  JPC_STICKY_FAULT_EN defined:
//   - An error in LOCKED enters state FAULT: locked=0, err_pulse fires once, err_count+1.
//   - FAULT then ignores all samples for checking but decode outputs still update.
//   - FAULT is left only via clear.
//  JPC_STICKY_FAULT_EN undefined: no FAULT state; an error in LOCKED returns to ACQ as above.
// TESTING
//  1. clear=1 for 2 cycles, then en=1 and drive the legal 10-code sequence from 00000 ->
//     phase 0..9 one cycle after each code; onehot=1<<phase; locked=1 after the 4th sample
//     (INIT + 3 successors); err_count=0.
//  2. Locked at phase 9, drive 00000 -> wrap accepted, phase=0, locked stays 1, no err_pulse.
//  3. Locked, drive 10100 -> legal=0, onehot=0, phase=0, err_pulse=1 for 1 cycle, err_count=1,
//     locked=0 (or stays in FAULT if JPC_STICKY_FAULT_EN is defined).
//  4. Locked at phase 3, skip to 11111 (phase 5) -> err_count+1 and locked drops.
//     Without the macro, 3 further successors relock.
//  5. Hold code 11000 for 5 enabled cycles -> no error and streak unchanged. Toggle en=0 for
//     3 cycles mid-sequence -> outputs frozen, err_pulse=0.
//  6. ERRW=2 with 5 injected errors -> err_count saturates at 3. Assert clear while locked
//     -> all outputs 0 on the next edge and FSM=INIT.

Source files
------------

// File: rtl/johnson_phase_checker.sv
// johnson_phase_checker: samples a twisted-ring (Johnson) counter, decodes it to a
// phase index and a one-hot phase vector, checks each sample against the previous
// one, and runs a lock state machine with a saturating error counter.
// Optional feature macro: JPC_STICKY_FAULT_EN (an error while locked parks the
// checker in FAULT until clear).
module johnson_phase_checker #(
  parameter int N        = 5,
  parameter int PW       = 4,
  parameter int ERRW     = 8,
  parameter int LOCK_CNT = 3
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            en,
  input  logic [N-1:0]    code,
  output logic [PW-1:0]   phase,
  output logic [2*N-1:0]  onehot,
  output logic            legal,
  output logic            locked,
  output logic            err_pulse,
  output logic [ERRW-1:0] err_count
);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  localparam logic [PW-1:0] LAST_PHASE = PW'(2 * N - 1);
  localparam logic [3:0]    LOCK_TGT   = 4'(LOCK_CNT);

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q;
  logic [2*N-1:0]  onehot_q;
  logic            legal_q;
  logic            err_pulse_q;
  logic [ERRW-1:0] err_count_q;
  logic [3:0]      streak_q;

  logic [PW-1:0]   phase_n;
  logic            legal_n;
  logic [PW-1:0]   succ_p;
  logic            chk_en;
  logic            is_succ;
  logic            is_hold;
  logic            err;
  logic            succ;
  logic [3:0]      streak_inc;

  // Code with the top k stages set and the rest clear.
  function automatic logic [N-1:0] lead_ones(input int unsigned k);
    logic [N-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < unsigned'(N); i++) begin
      if (i < k) v[N-1-i] = 1'b1;
    end
    return v;
  endfunction

  // Decode the incoming code to a phase index; illegal codes give phase 0.
  always_comb begin
    legal_n = 1'b0;
    phase_n = '0;
    for (int unsigned k = 0; k <= unsigned'(N); k++) begin
      if (code == lead_ones(k)) begin
        legal_n = 1'b1;
        phase_n = PW'(k);
      end
    end
    for (int unsigned m = 1; m < unsigned'(N); m++) begin
      if (code == ~lead_ones(m)) begin
        legal_n = 1'b1;
        phase_n = PW'(unsigned'(N) + m);
      end
    end
  end

  // Classify the enabled sample against the previously registered phase.
  always_comb begin
    succ_p     = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
    chk_en     = en && (state_q == S_ACQ || state_q == S_LOCKED);
    is_succ    = legal_q && legal_n && (phase_n == succ_p);
    is_hold    = legal_q && legal_n && (phase_n == phase_q);
    // A sample after an illegal one only reloads the reference phase, but an
    // illegal code itself is always an error outside FAULT.
    err        = (en && state_q == S_INIT && !legal_n) ||
                 (chk_en && (!legal_n || (legal_q && !is_succ && !is_hold)));
    succ       = chk_en && is_succ;
    streak_inc = (streak_q >= LOCK_TGT) ? LOCK_TGT : streak_q + 4'd1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (clear) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   if (en) state_d = S_ACQ;
      S_ACQ:    if (succ && !err && streak_inc == LOCK_TGT) state_d = S_LOCKED;
      S_LOCKED: begin
`ifdef JPC_STICKY_FAULT_EN
        if (err) state_d = S_FAULT;
`else
        if (err) state_d = S_ACQ;
`endif
      end
      default:  state_d = state_q;
    endcase
  end

  // FSM outputs.
  always_comb begin
    locked = (state_q == S_LOCKED);
  end

  // Decode registers, streak and error accounting.
  always_ff @(posedge clk) begin
    if (clear) begin
      phase_q     <= '0;
      onehot_q    <= '0;
      legal_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      streak_q    <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (en) begin
        phase_q     <= phase_n;
        onehot_q    <= legal_n ? ({{(2*N-1){1'b0}}, 1'b1} << phase_n) : '0;
        legal_q     <= legal_n;
        err_pulse_q <= err;
        if (err) begin
          streak_q <= '0;
          if (err_count_q != '1) err_count_q <= err_count_q + 1'b1;
        end else if (succ) begin
          streak_q <= streak_inc;
        end
      end
    end
  end

  assign phase     = phase_q;
  assign onehot    = onehot_q;
  assign legal     = legal_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_johnson_phase_checker.sv
// Self-checking bench for johnson_phase_checker: directed scenarios followed by
// randomized samples, compared against a phase-number reference model.
// A second instance with a 2-bit error counter shares the stimulus.
module tb_johnson_phase_checker;

  localparam int N        = 5;
  localparam int PW       = 4;
  localparam int LOCK_CNT = 3;

  logic          clk = 1'b0;
  logic          clear = 1'b0;
  logic          en = 1'b0;
  logic [N-1:0]  code = '0;

  logic [PW-1:0] phase_a, phase_b;
  logic [9:0]    onehot_a, onehot_b;
  logic          legal_a, legal_b, locked_a, locked_b, pulse_a, pulse_b;
  logic [7:0]    cnt_a;
  logic [1:0]    cnt_b;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_phase, m_legal, m_st, m_pulse, m_cnt8, m_cnt2, m_streak;

  always #5 clk = ~clk;

  johnson_phase_checker #(.N(N), .PW(PW), .ERRW(8), .LOCK_CNT(LOCK_CNT)) dut_a (
    .clk(clk), .clear(clear), .en(en), .code(code),
    .phase(phase_a), .onehot(onehot_a), .legal(legal_a), .locked(locked_a),
    .err_pulse(pulse_a), .err_count(cnt_a)
  );

  johnson_phase_checker #(.N(N), .PW(PW), .ERRW(2), .LOCK_CNT(LOCK_CNT)) dut_b (
    .clk(clk), .clear(clear), .en(en), .code(code),
    .phase(phase_b), .onehot(onehot_b), .legal(legal_b), .locked(locked_b),
    .err_pulse(pulse_b), .err_count(cnt_b)
  );

  // Ring state for phase p: p ones followed by zeros, or (p-5) zeros followed by ones.
  function automatic logic [4:0] code_of(input int p);
    int v;
    if (p <= 5) v = ((1 << p) - 1) << (5 - p);
    else        v = (1 << (10 - p)) - 1;
    return 5'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model states: 0 init, 1 acquiring, 2 locked, 3 fault
  task automatic model(input bit c_clr, input bit c_en, input logic [4:0] c);
    int q, lg, e, s;
    if (c_clr) begin
      m_phase = 0; m_legal = 0; m_st = 0; m_pulse = 0;
      m_cnt8 = 0; m_cnt2 = 0; m_streak = 0;
      return;
    end
    if (!c_en) begin
      m_pulse = 0;
      return;
    end
    lg = 0; q = 0;
    for (int p = 0; p < 10; p++) if (code_of(p) == c) begin lg = 1; q = p; end
    e = 0; s = 0;
    case (m_st)
      0: begin e = !lg; m_st = 1; end
      1, 2: begin
        if (!lg) e = 1;
        else if (m_legal) begin
          if (q == (m_phase + 1) % 10) s = 1;
          else if (q != m_phase) e = 1;
        end
      end
      default: ;
    endcase
    if (e) begin
      m_streak = 0;
`ifdef JPC_STICKY_FAULT_EN
      if (m_st == 2) m_st = 3;
`else
      if (m_st == 2) m_st = 1;
`endif
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end else if (s) begin
      if (m_streak < LOCK_CNT) m_streak++;
      if (m_st == 1 && m_streak == LOCK_CNT) m_st = 2;
    end
    m_pulse = e;
    m_legal = lg;
    m_phase = lg ? q : 0;
  endtask

  task automatic step(input bit c_en, input logic [4:0] c, input bit c_clr);
    @(negedge clk);
    clear = c_clr; en = c_en; code = c;
    @(posedge clk);
    model(c_clr, c_en, c);
    #1;
    chk("phase",      32'(phase_a),  32'(m_phase));
    chk("onehot",     32'(onehot_a), m_legal ? (32'd1 << m_phase) : 32'd0);
    chk("legal",      32'(legal_a),  32'(m_legal));
    chk("locked",     32'(locked_a), 32'(m_st == 2));
    chk("err_pulse",  32'(pulse_a),  32'(m_pulse));
    chk("err_count",  32'(cnt_a),    32'(m_cnt8));
    chk("err_count2", 32'(cnt_b),    32'(m_cnt2));
    chk("locked2",    32'(locked_b), 32'(m_st == 2));
  endtask

  task automatic sp(input int p);
    step(1'b1, code_of(p), 1'b0);
  endtask

  initial begin
    int r;
    logic [4:0] rc;
    // reset for two cycles
    step(1'b0, 5'b00000, 1'b1);
    step(1'b0, 5'b00000, 1'b1);
    chk("reset_phase", 32'(phase_a), 32'd0);
    chk("reset_count", 32'(cnt_a), 32'd0);
    // full legal cycle, lock after the 4th sample
    for (int p = 0; p < 10; p++) begin
      sp(p);
      if (p == 3) chk("lock_after_4", 32'(locked_a), 32'd1);
    end
    // wrap 9 -> 0
    sp(0);
    chk("wrap_locked", 32'(locked_a), 32'd1);
    chk("wrap_no_err", 32'(pulse_a), 32'd0);
    // illegal code while locked
    step(1'b1, 5'b10100, 1'b0);
    chk("illegal_pulse", 32'(pulse_a), 32'd1);
    chk("illegal_count", 32'(cnt_a), 32'd1);
    // relock, then skip phase 3 -> 5
    for (int p = 1; p <= 9; p++) sp(p);
    for (int p = 0; p <= 3; p++) sp(p);
    sp(5);
    chk("skip_unlock", 32'(locked_a), 32'd0);
    for (int p = 6; p <= 8; p++) sp(p);
    // hold 11000 five times with an en=0 gap
    sp(9); sp(0); sp(1);
    for (int i = 0; i < 3; i++) sp(2);
    for (int i = 0; i < 3; i++) step(1'b0, 5'b10101, 1'b0);
    for (int i = 0; i < 2; i++) sp(2);
    sp(3);
    // five errors: 2-bit counter saturates
    sp(0); sp(5); sp(0); sp(5); sp(0);
    chk("sat2", 32'(cnt_b), 32'd3);
    // relock, clear mid-operation, then a fresh first sample
    for (int p = 1; p <= 5; p++) sp(p);
    step(1'b1, code_of(6), 1'b1);
    chk("clr_locked", 32'(locked_a), 32'd0);
    chk("clr_onehot", 32'(onehot_a), 32'd0);
    sp(1);
    // randomized samples
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(99);
      if (r < 2)       step(1'b1, 5'($urandom), 1'b1);
      else if (r < 12) step(1'b0, 5'($urandom), 1'b0);
      else if (r < 55) sp(m_legal ? (m_phase + 1) % 10 : $urandom_range(9));
      else if (r < 70) sp(m_phase);
      else if (r < 85) sp($urandom_range(9));
      else begin
        rc = 5'($urandom);
        step(1'b1, rc, 1'b0);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
